// File: rtl/inv_rotate.sv
// Inverse rho step: buffers a full 64-slice state, then emits slices with each
// lane rotated back by its offset. Two-state LOAD/EMIT flow with valid/ready on both sides.
module inv_rotate (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] in_slice,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [24:0] out_slice,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_idx,
    output logic        done
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Lane offsets packed with lane 0 in the least significant 6 bits.
    localparam logic [25*6-1:0] ROT = {
        6'd14, 6'd56, 6'd61, 6'd2,  6'd18,
        6'd8,  6'd21, 6'd15, 6'd45, 6'd41,
        6'd39, 6'd25, 6'd43, 6'd10, 6'd3,
        6'd20, 6'd55, 6'd6,  6'd44, 6'd36,
        6'd27, 6'd28, 6'd62, 6'd1,  6'd0
    };

    state_t      state_q, state_d;
    logic [5:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  out_idx_q, out_idx_d;
    logic        done_q, done_d;
    logic        wr_en;
    logic [24:0] mem_q [64];
    logic [24:0] mem_d [64];
    logic [5:0]  rd_idx [25];

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        out_idx_d  = out_idx_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en      = 1'b1;
                    load_cnt_d = load_cnt_q + 6'd1;
                    if (load_cnt_q == 6'd63) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_idx_d = out_idx_q + 6'd1;
                    if (out_idx_q == 6'd63) begin
                        done_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 6'd0;
            out_idx_q  <= 6'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            out_idx_q  <= out_idx_d;
            done_q     <= done_d;
        end
    end

    // State buffer is deliberately left out of reset; only the counters gate its use.
    always_comb begin
        for (int k = 0; k < 64; k++) begin
            mem_d[k] = (wr_en && (load_cnt_q == 6'(k))) ? in_slice : mem_q[k];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Each lane bit reads its own slice: index wraps mod 64 by 6-bit truncation.
    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_lane
            assign rd_idx[gi]    = out_idx_q + ROT[gi*6 +: 6];
            assign out_slice[gi] = mem_q[rd_idx[gi]][gi];
        end
    endgenerate

    assign out_idx = out_idx_q;
    assign done    = done_q;

endmodule

// File: tb/tb_inv_rotate.sv
// Self-checking bench for inv_rotate: randomized states pushed through a behavioural
// forward rotate, then the block must reproduce the original slices in order.
module tb_inv_rotate;

    logic        clk;
    logic        rst;
    logic [24:0] in_slice;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] out_slice;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic        done;

    int checks;
    int failures;

    int          rot [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                              41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
    logic [24:0] orig [64];
    logic [24:0] stim [64];
    logic [24:0] expv [64];

    inv_rotate dut (
        .clk       (clk),
        .rst       (rst),
        .in_slice  (in_slice),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_slice (out_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keccak rho: lane bit at z moves to z + r, so output slice z takes input slice z - r.
    task automatic make_forward();
        for (int z = 0; z < 64; z++) begin
            for (int i = 0; i < 25; i++) begin
                stim[z][i] = orig[(z - rot[i] + 64) % 64][i];
            end
        end
    endtask

    task automatic randomize_orig();
        for (int z = 0; z < 64; z++) orig[z] = 25'($urandom);
    endtask

    // Push stim[0..63]; in_valid dropped with probability gap_pct.
    task automatic load_state(input int gap_pct);
        int n;
        int budget;
        n = 0;
        budget = 0;
        while (n < 64 && budget < 1000) begin
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_slice = 25'($urandom);
            end else begin
                in_valid = 1'b1;
                in_slice = stim[n];
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_phase slice=%0d in_ready=%b out_valid=%b required 1/0", n, in_ready, out_valid);
            end
            step();
            if (in_valid) n++;
            budget++;
        end
        in_valid = 1'b0;
        if (n < 64) begin
            checks++;
            failures++;
            $display("FAIL load_timeout loaded=%0d required 64", n);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL emit_latency out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
    endtask

    // Accept n_out slices against expv; if all 64 are taken, check the done pulse.
    task automatic drain(input int n_out, input int stall_pct, input bit b2b);
        int          z;
        int          budget;
        bit          stalled;
        logic [24:0] held_slice;
        logic [5:0]  held_idx;
        z = 0;
        budget = 0;
        stalled = 1'b0;
        held_slice = '0;
        held_idx = '0;
        while (z < n_out && budget < 2000) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL emit_valid z=%0d out_valid=%b in_ready=%b required 1/0", z, out_valid, in_ready);
            end
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_early z=%0d done=%b required 0", z, done);
            end
            if (stalled) begin
                checks++;
                if (out_slice !== held_slice || out_idx !== held_idx) begin
                    failures++;
                    $display("FAIL stall_stable slice=%h idx=%0d required %h/%0d", out_slice, out_idx, held_slice, held_idx);
                end
            end
            checks++;
            if (out_idx !== 6'(z)) begin
                failures++;
                $display("FAIL out_idx got=%0d required %0d", out_idx, z);
            end
            checks++;
            if (out_slice !== expv[z]) begin
                failures++;
                $display("FAIL out_slice z=%0d got=%h required %h", z, out_slice, expv[z]);
            end
            out_ready  = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
            in_valid   = 1'($urandom);
            in_slice   = 25'($urandom);
            held_slice = out_slice;
            held_idx   = out_idx;
            stalled    = !out_ready;
            step();
            if (out_ready) begin
                $display("slice z=%0d out=%h", z, held_slice);
                z++;
            end
            budget++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (z < n_out) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout accepted=%0d required %0d", z, n_out);
        end
        if (n_out == 64) begin
            checks++;
            if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse done=%b in_ready=%b out_valid=%b required 1/1/0", done, in_ready, out_valid);
            end
            if (!b2b) begin
                step();
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL done_width done=%b required 0", done);
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || out_idx !== 6'd0) begin
            failures++;
            $display("FAIL %s in_ready=%b out_valid=%b done=%b out_idx=%0d required 1/0/0/0", tag, in_ready, out_valid, done, out_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        check_idle("reset_state");
        rst = 1'b1;
        step();
        check_idle("after_reset");
        $display("test_reset done");
    endtask

    task automatic test_single_lane(input logic [24:0] pattern, input int hot_idx);
        for (int z = 0; z < 64; z++) begin
            stim[z] = '0;
            expv[z] = '0;
        end
        stim[0] = pattern;
        expv[hot_idx] = pattern;
        load_state(0);
        drain(64, 0, 1'b0);
        $display("test_single_lane pattern=%h hot=%0d", pattern, hot_idx);
    endtask

    task automatic test_all_ones();
        for (int z = 0; z < 64; z++) begin
            stim[z] = 25'h1FFFFFF;
            expv[z] = 25'h1FFFFFF;
        end
        load_state(0);
        drain(64, 0, 1'b0);
        $display("test_all_ones done");
    endtask

    task automatic test_roundtrip(input int gap_pct, input int stall_pct);
        randomize_orig();
        make_forward();
        expv = orig;
        load_state(gap_pct);
        drain(64, stall_pct, 1'b0);
        $display("test_roundtrip gap=%0d stall=%0d", gap_pct, stall_pct);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            randomize_orig();
            make_forward();
            expv = orig;
            load_state(0);
            drain(64, 20, 1'b1);
        end
        step();
        check_idle("b2b_idle");
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_load();
        for (int z = 0; z < 30; z++) begin
            in_valid = 1'b1;
            in_slice = 25'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_idle("reset_mid_load");
        randomize_orig();
        make_forward();
        expv = orig;
        load_state(0);
        drain(64, 0, 1'b0);
        $display("test_reset_mid_load done");
    endtask

    task automatic test_reset_mid_emit();
        randomize_orig();
        make_forward();
        expv = orig;
        load_state(0);
        drain(10, 30, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_idle("reset_mid_emit");
        step();
        check_idle("reset_no_done");
        $display("test_reset_mid_emit done");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_slice  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_lane(25'h0000002, 63);
        test_single_lane(25'h0000004, 2);
        test_all_ones();
        test_roundtrip(0, 0);
        test_roundtrip(40, 50);
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_rotate.md
INV_ROTATE -- requirements
Module: inv_rotate

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have port in_slice, input, 25 bits: one state slice; bit i = x + 5*y.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_slice holds valid data.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts in_slice this cycle.
REQ-006 The block SHALL have port out_slice, output, 25 bits: the inverse-rotated slice at index out_idx.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_slice is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_slice this cycle.
REQ-009 The block SHALL have port out_idx, output, 6 bits: slice index z of out_slice.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final slice is accepted.

Function
REQ-011 The block SHALL buffer one full state of 64 slices x 25 bits in internal registers.
REQ-012 The block SHALL use a two-state FSM: LOAD (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-013 In LOAD, each cycle with in_valid=1 SHALL write in_slice to buffer[load_cnt] and increment the 6-bit load_cnt.
REQ-014 An input handshake with load_cnt=63 SHALL move the FSM to EMIT on the next edge and wrap load_cnt to 0.
REQ-015 out_valid SHALL rise on the cycle after the 64th input handshake (one-cycle latency).
REQ-016 In EMIT, out_slice bit i SHALL equal buffer[(out_idx + r[i]) mod 64] bit i, i.e. the inverse of the forward rotate step.
REQ-017 The rotation offsets r[i] for i = 0..24 SHALL be: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
REQ-018 Offset addition SHALL be 6-bit modulo-64, with wrap-around discarding the carry.
REQ-019 out_idx SHALL start at 0 in EMIT and increment on each cycle with out_valid=1 and out_ready=1.
REQ-020 While out_ready=0, out_slice and out_idx SHALL stay stable.
REQ-021 An output handshake with out_idx=63 SHALL assert done for exactly the next cycle, return the FSM to LOAD, and wrap out_idx to 0.
REQ-022 Input data SHALL be ignored while in EMIT, since in_ready=0.
REQ-023 done SHALL be 0 in every cycle except the one defined in REQ-021.
REQ-024 The block SHALL back-to-back process states: a new LOAD may accept data in the same cycle that done=1.

Reset
REQ-025 While rst=0 at a rising clk edge, the FSM SHALL go to LOAD and load_cnt and out_idx SHALL be cleared to 0.
REQ-026 Reset output values SHALL be: in_ready=1, out_valid=0, done=0, out_idx=0.
REQ-027 Buffer contents SHALL NOT be reset; out_slice is don't-care while out_valid=0.
REQ-028 A reset applied mid-LOAD or mid-EMIT SHALL discard the partial state, with no done pulse.

Verification
REQ-029 The bench SHALL cover this scenario: load slice 0 = 25'h0000002 (lane 1), all others 0 -> only out_idx=63 has out_slice=25'h0000002.
REQ-030 The bench SHALL cover this scenario: load slice 0 = 25'h0000004 (lane 2, r=62) -> only out_idx=2 has out_slice=25'h0000004.
REQ-031 The bench SHALL cover this scenario: all 64 slices = 25'h1FFFFFF -> every output = 25'h1FFFFFF, and done pulses once, exactly one cycle after the out_idx=63 handshake.
REQ-032 The bench SHALL cover this scenario: random state passed through the forward rotate step and then this block -> output equals the original state for all 64 slices.
REQ-033 The bench SHALL cover this scenario: out_ready toggled randomly and in_valid with gaps -> no lost or duplicated slices, and out_slice is stable while stalled.
REQ-034 The bench SHALL cover this scenario: rst=0 after 30 loaded slices, then a full new state -> output reflects only the new state, with out_valid first at cycle 65 of the new load.
